// File: rtl/pwm_compare_gen.sv
// Output-compare PWM generator: double-buffered period/compare/dead time,
// complementary high/low gate drive with dead-time insertion between edges.
module pwm_compare_gen #(
  parameter int CTR_LEN = 9,
  parameter int DT_LEN  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [CTR_LEN-1:0] period,
  input  logic [CTR_LEN-1:0] compare,
  input  logic [DT_LEN-1:0]  dead_time,
  input  logic               load,
  output logic               pending,
  output logic               load_ack,
  output logic               cycle_start,
  output logic               pwm_hi,
  output logic               pwm_lo
);

  typedef enum logic [1:0] {
    ST_DEAD = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } state_t;

  logic [CTR_LEN-1:0] ctr;
  logic [CTR_LEN-1:0] act_period;
  logic [CTR_LEN-1:0] act_compare;
  logic [CTR_LEN-1:0] sh_period;
  logic [CTR_LEN-1:0] sh_compare;
  logic [DT_LEN-1:0]  act_dt;
  logic [DT_LEN-1:0]  sh_dt;
  logic [DT_LEN-1:0]  dt_cnt;
  logic [DT_LEN-1:0]  dt_cnt_nxt;
  state_t             state;
  state_t             state_nxt;
  logic               en_q;
  logic               raw;
  logic               raw_q;
  logic               restart;
  logic               wrap;
  logic               transfer;
  logic               hi_nxt;
  logic               lo_nxt;

  function automatic logic [DT_LEN-1:0] sat_dec(input logic [DT_LEN-1:0] v);
    return (v == '0) ? '0 : v - DT_LEN'(1);
  endfunction

  assign wrap     = enable && (ctr == act_period);
  // While disabled there is no period boundary to wait for, so a pending shadow moves at once.
  assign transfer = pending && (wrap || !enable);
  assign raw      = (ctr < act_compare);

  // cycle_start is registered off the wrap so it lands on the ctr==0 cycle together with load_ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr         <= '0;
      act_period  <= '0;
      act_compare <= '0;
      act_dt      <= '0;
      sh_period   <= '0;
      sh_compare  <= '0;
      sh_dt       <= '0;
      pending     <= 1'b0;
      load_ack    <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      if (!enable || wrap) ctr <= '0;
      else                 ctr <= ctr + 1'b1;
      if (load) begin
        sh_period  <= period;
        sh_compare <= compare;
        sh_dt      <= dead_time;
      end
      if (transfer) begin
        act_period  <= sh_period;
        act_compare <= sh_compare;
        act_dt      <= sh_dt;
      end
      pending     <= load | (pending & ~transfer);
      load_ack    <= transfer;
      cycle_start <= wrap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_DEAD;
      dt_cnt <= '0;
      en_q   <= 1'b0;
      raw_q  <= 1'b0;
      pwm_hi <= 1'b0;
      pwm_lo <= 1'b0;
    end else begin
      state  <= state_nxt;
      dt_cnt <= dt_cnt_nxt;
      en_q   <= enable;
      raw_q  <= raw;
      pwm_hi <= hi_nxt;
      pwm_lo <= lo_nxt;
    end
  end

  // First enabled cycle is treated like an edge of raw so the dead band precedes any drive.
  always_comb begin
    state_nxt  = state;
    dt_cnt_nxt = dt_cnt;
    restart    = 1'b0;
    if (!enable) begin
      state_nxt  = ST_DEAD;
      dt_cnt_nxt = '0;
    end else begin
      case (state)
        ST_HI:   restart = !raw;
        ST_LO:   restart = raw;
        default: restart = (raw != raw_q);
      endcase
      if (!en_q || restart) begin
        if (act_dt == '0) begin
          state_nxt  = raw ? ST_HI : ST_LO;
          dt_cnt_nxt = '0;
        end else begin
          state_nxt  = ST_DEAD;
          dt_cnt_nxt = act_dt;
        end
      end else if (state == ST_DEAD) begin
        if (dt_cnt <= DT_LEN'(1)) begin
          state_nxt  = raw ? ST_HI : ST_LO;
          dt_cnt_nxt = '0;
        end else begin
          dt_cnt_nxt = sat_dec(dt_cnt);
        end
      end
    end
  end

  always_comb begin
    hi_nxt = (state_nxt == ST_HI);
    lo_nxt = (state_nxt == ST_LO);
  end

endmodule

// File: doc/pwm_compare_gen.md
# pwm_compare_gen

Output-compare PWM generator for the SMPS power stage. It produces a complementary high-side/low-side gate-drive pair with programmable period, duty compare and dead time. Period, compare and dead time are double-buffered so updates take effect only at a period boundary. It is the drive-side counterpart of the input-capture block: capture measures pulses on a pin, this block generates them.

## Interface
- CTR_LEN, 9, width of period counter, period and compare
- DT_LEN, 4, width of dead-time value and counter

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run PWM; low forces both gate outputs low
- period  in  CTR_LEN  shadow period; cycle length is period+1 clocks
- compare  in  CTR_LEN  shadow compare; raw high while ctr < compare
- dead_time  in  DT_LEN  shadow dead time in clocks
- load  in  1  single-cycle strobe; captures period/compare/dead_time into shadow
- pending  out  1  shadow holds values not yet applied
- load_ack  out  1  one-cycle pulse when shadow is copied to active
- cycle_start  out  1  one-cycle pulse in each cycle where enable=1 and ctr==0
- pwm_hi  out  1  high-side gate drive
- pwm_lo  out  1  low-side gate drive

## Operation
- Reset: ctr=0; active and shadow registers=0; pending=0; load_ack=0; cycle_start=0; pwm_hi=0; pwm_lo=0; dead-time counter=0.
- load=1: shadow <= inputs and pending <= 1 on the next edge. A load while pending is already set overwrites the shadow; only one load_ack is issued.
- Counter, enable=1: ctr increments each clock. When ctr==active_period, next ctr=0 (wrap).
- Transfer at wrap: if pending=1, active <= shadow, pending <= 0, and load_ack pulses. A load in the same cycle as a wrap is not applied at that wrap; it is applied at the next wrap.
- enable=0:
  - ctr held at 0; pwm_hi=pwm_lo=0; dead-time counter cleared.
  - A pending shadow transfers on the next clock, with load_ack.
- raw = (ctr < active_compare).
  - compare=0 gives 0% duty.
  - compare > period gives 100% duty.
- Dead-time FSM, states HI, LO, DEAD:
  - Change of raw in HI or LO: both outputs low, enter DEAD, counter = active_dead_time.
  - DEAD decrements each clock. On reaching 0 it enters HI if raw=1, else LO.
  - A raw change during DEAD reloads the counter.
  - dead_time=0: DEAD is skipped; the outputs follow raw directly.
- First cycle after enable rises: state is DEAD with the counter loaded. Both outputs remain low for dead_time clocks before either output asserts.
- Invariant: pwm_hi and pwm_lo are never both 1, in any cycle, for any input sequence.
- Arithmetic: all counters are unsigned. ctr never exceeds active_period. There are no wrap-around hazards, because the period is at most 2^CTR_LEN-1.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Gate outputs reflect raw with 1 clock of latency when dead_time=0.
- Per cycle with 0 < compare ≤ period and dead_time=d:
  - pwm_hi high for compare−d clocks (0 if negative).
  - pwm_lo high for period+1−compare−d clocks (0 if negative).
- cycle_start and load_ack coincide at a transfer wrap, and new active values affect raw starting at that ctr=0.
- Asynchronous reset mid-cycle: outputs go low immediately; the pending load is lost.

## Test plan
- Reset, then period=9, compare=3, dead_time=0, load, enable:
  - load_ack pulses once.
  - pwm_hi is high 3 of every 10 clocks and pwm_lo 7.
  - cycle_start fires every 10 clocks.
- period=9, compare=3, dead_time=1:
  - pwm_hi high 2 clocks, pwm_lo high 6 clocks.
  - One both-low clock at each edge.
  - pwm_hi & pwm_lo == 0 checked every cycle.
- Running at compare=3, load compare=7 mid-cycle (ctr=4):
  - The current cycle keeps the 3-clock high.
  - load_ack at the next ctr=0; the following cycle is high 7 clocks.
  - pending is high between load and ack.
- Boundary duties: compare=0 gives pwm_hi never high; compare=15 with period=9 gives pwm_hi constantly high after the first dead time. dead_time=5 with compare=3 gives pwm_hi never high.
- Two loads before one wrap (compare 4 then 6): a single load_ack, and compare 6 is applied.
- Stress disable and reset:
  - enable drop mid-pulse: both outputs low the next clock, ctr=0.
  - rst asserted mid-cycle: all outputs 0 asynchronously; the state after release matches the reset values.
